// File: rtl/cpu_subsys_mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
// Holds the FSM state encoding, the requester ID type and default sizes.
package cpu_subsys_pkg;

    localparam int ADDR_W_DEF  = 30;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_M0 = 1'b0;
    localparam req_id_t REQ_M1 = 1'b1;

endpackage

// File: rtl/cpu_subsys_mem_arb_if.sv
// Simple valid/ready word-addressed memory bus.
// The master modport issues requests; the slave modport returns responses.
interface cpu_subsys_mem_arb_if
    import cpu_subsys_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;

    modport master (output valid, addr, write, wdata, wstrb,
                    input  rdata, ready, err);
    modport slave  (input  valid, addr, write, wdata, wstrb,
                    output rdata, ready, err);
endinterface

// File: rtl/cpu_subsys_mem_arb_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, on a tie the
// requester that did not win last time is chosen. Purely combinational.
module cpu_subsys_rr_arb2
    import cpu_subsys_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == REQ_M0) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/cpu_subsys_mem_arb.sv
// Arbitrates two requesters onto one registered downstream memory port.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> IDLE.
module cpu_subsys_mem_arb
    import cpu_subsys_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_subsys_mem_arb_if.slave  m0,
    cpu_subsys_mem_arb_if.slave  m1,
    cpu_subsys_mem_arb_if.master s
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    arb_state_e        state_q, state_d;
    req_id_t           grant_q, grant_d;
    req_id_t           last_grant_q, last_grant_d;
    logic              s_valid_q, s_valid_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic              s_write_q, s_write_d;
    logic [31:0]       s_wdata_q, s_wdata_d;
    logic [3:0]        s_wstrb_q, s_wstrb_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;

    logic [1:0]        req_vec;
    logic [1:0]        gnt_oh;
    logic              cpl;
    logic [1:0]        rsp_ready;
    logic [1:0]        rsp_err;
    logic [31:0]       rsp_rdata [2];

    assign req_vec = {m1.valid, m0.valid};

    cpu_subsys_rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .gnt        (gnt_oh)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_valid_d    = 1'b0;
        s_addr_d     = s_addr_q;
        s_write_d    = s_write_q;
        s_wdata_d    = s_wdata_q;
        s_wstrb_d    = s_wstrb_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt_oh) begin
                    grant_d      = gnt_oh[1] ? REQ_M1 : REQ_M0;
                    last_grant_d = grant_d;
                    s_valid_d    = 1'b1;
                    s_addr_d     = gnt_oh[1] ? m1.addr  : m0.addr;
                    s_write_d    = gnt_oh[1] ? m1.write : m0.write;
                    // Reads carry no data or byte enables downstream.
                    s_wdata_d    = s_write_d ? (gnt_oh[1] ? m1.wdata : m0.wdata) : 32'h0;
                    s_wstrb_d    = s_write_d ? (gnt_oh[1] ? m1.wstrb : m0.wstrb) : 4'h0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = 8'd0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (s.ready || (wait_cnt_q == TIMEOUT_CNT)) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_M0;
            last_grant_q <= REQ_M1;
            s_valid_q    <= 1'b0;
            s_addr_q     <= '0;
            s_write_q    <= 1'b0;
            s_wdata_q    <= 32'h0;
            s_wstrb_q    <= 4'h0;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_valid_q    <= s_valid_d;
            s_addr_q     <= s_addr_d;
            s_write_q    <= s_write_d;
            s_wdata_q    <= s_wdata_d;
            s_wstrb_q    <= s_wstrb_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Completion is either a real slave response or the timeout expiring;
    // a real response wins if both land in the same cycle.
    assign cpl = (state_q == ST_WAIT) && (s.ready || (wait_cnt_q == TIMEOUT_CNT));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_ready[gi] = cpl && (grant_q == req_id_t'(gi));
            assign rsp_err[gi]   = rsp_ready[gi] && !s.ready;
            assign rsp_rdata[gi] = (rsp_ready[gi] && s.ready) ? s.rdata : 32'h0;
        end
    endgenerate

    assign m0.ready = rsp_ready[0];
    assign m0.err   = rsp_err[0];
    assign m0.rdata = rsp_rdata[0];
    assign m1.ready = rsp_ready[1];
    assign m1.err   = rsp_err[1];
    assign m1.rdata = rsp_rdata[1];

    assign s.valid = s_valid_q;
    assign s.addr  = s_addr_q;
    assign s.write = s_write_q;
    assign s.wdata = s_wdata_q;
    assign s.wstrb = s_wstrb_q;

endmodule
